// File: rtl/rk8e_dma_bridge.sv
// rk8e_dma_bridge: cycle-steal DMA bridge between the RK8E disk engine and
// PDP-8 main memory. Each request from sd becomes exactly one memory access,
// made while the CPU is parked off the bus.
module rk8e_dma_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        dmaREQ,
  input  logic        dmaRD,
  input  logic        dmaWR,
  input  logic [0:14] dmaADDR,
  input  logic [0:11] dmaDOUT,
  output logic        dmaGNT,
  output logic [0:11] dmaDIN,
  output logic        cpuHOLD,
  input  logic        cpuACK,
  output logic [0:14] memADDR,
  output logic [0:11] memDOUT,
  output logic        memRD,
  output logic        memWR,
  input  logic [0:11] memDIN,
  output logic [0:11] xferCOUNT,
  output logic        dmaERR
);

  // Request as captured from sd when it is accepted in IDLE.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [0:14] addr;
    logic [0:11] data;
  } dmaReq_t;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    MEM,
    RDWAIT,
    DONE,
    RELEASE
  } state_t;

  state_t  state, stateNext;
  dmaReq_t req;
  logic    clr;
  logic    isRd, isWr, legal;

  // reset and IOCLR behave identically and win over everything else.
  assign clr   = reset | clear;

  // Exactly one of RD/WR must be set; both or neither is an illegal request.
  assign isRd  =  req.rd & ~req.wr;
  assign isWr  = ~req.rd &  req.wr;
  assign legal = isRd | isWr;

  // Memory address and write data come straight from the latched request,
  // so they are registered and stable across the whole MEM cycle.
  assign memADDR = req.addr;
  assign memDOUT = req.data;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= stateNext;
  end

  // Latch the request on acceptance; sd's live inputs are not used afterwards.
  always_ff @(posedge clk) begin
    if (clr)                         req <= '0;
    else if (state == IDLE && dmaREQ) req <= '{rd: dmaRD, wr: dmaWR, addr: dmaADDR, data: dmaDOUT};
  end

  // Read data is captured the cycle after the read strobe and held until the next read.
  always_ff @(posedge clk) begin
    if (clr)                  dmaDIN <= '0;
    else if (state == RDWAIT) dmaDIN <= memDIN;
  end

  // Sticky illegal-request flag, raised when the bad request reaches memory.
  always_ff @(posedge clk) begin
    if (clr)                         dmaERR <= 1'b0;
    else if (state == MEM && !legal) dmaERR <= 1'b1;
  end

  // Count legal transfers as they complete; wraps naturally at 12 bits.
  always_ff @(posedge clk) begin
    if (clr)                       xferCOUNT <= '0;
    else if (state == DONE && legal) xferCOUNT <= xferCOUNT + 12'd1;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    stateNext = state;
    cpuHOLD   = 1'b0;
    memRD     = 1'b0;
    memWR     = 1'b0;
    dmaGNT    = 1'b0;
    case (state)
      IDLE: begin
        if (dmaREQ) stateNext = HOLD;
      end
      HOLD: begin
        cpuHOLD = 1'b1;
        if (cpuACK) stateNext = MEM;
      end
      MEM: begin
        cpuHOLD = 1'b1;
        memWR   = isWr;
        memRD   = isRd;
        stateNext = isRd ? RDWAIT : DONE;
      end
      RDWAIT: begin
        cpuHOLD   = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        cpuHOLD   = 1'b1;
        dmaGNT    = 1'b1;
        stateNext = RELEASE;
      end
      RELEASE: begin
        // A request still high here is the one just serviced; wait for it to drop.
        if (!dmaREQ) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rk8e_dma_bridge.sv
// Self-checking bench for rk8e_dma_bridge. Each directed transfer is turned
// into a per-cycle schedule of expected outputs; one compare process checks
// the DUT against that schedule every cycle.
module tb_rk8e_dma_bridge;

  localparam int MAXC = 32768;

  logic        clk, reset, clear;
  logic        dmaREQ, dmaRD, dmaWR;
  logic [0:14] dmaADDR;
  logic [0:11] dmaDOUT;
  logic        dmaGNT;
  logic [0:11] dmaDIN;
  logic        cpuHOLD, cpuACK;
  logic [0:14] memADDR;
  logic [0:11] memDOUT;
  logic        memRD, memWR;
  logic [0:11] memDIN;
  logic [0:11] xferCOUNT;
  logic        dmaERR;

  rk8e_dma_bridge dut (
    .clk(clk), .reset(reset), .clear(clear),
    .dmaREQ(dmaREQ), .dmaRD(dmaRD), .dmaWR(dmaWR),
    .dmaADDR(dmaADDR), .dmaDOUT(dmaDOUT),
    .dmaGNT(dmaGNT), .dmaDIN(dmaDIN),
    .cpuHOLD(cpuHOLD), .cpuACK(cpuACK),
    .memADDR(memADDR), .memDOUT(memDOUT),
    .memRD(memRD), .memWR(memWR), .memDIN(memDIN),
    .xferCOUNT(xferCOUNT), .dmaERR(dmaERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k is the interval following the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array: read data appears exactly one cycle after memRD.
  logic [0:11] memArr [MAXC];
  always @(posedge clk) begin
    if (memWR === 1'b1) memArr[memADDR] <= memDOUT;
    memDIN <= (memRD === 1'b1) ? memArr[memADDR] : 12'o5252;
  end

  // Expected-output schedule, indexed by cycle.
  bit          eRd[MAXC], eWr[MAXC], eGnt[MAXC], eHold[MAXC];
  bit          eCnt[MAXC], eErr[MAXC], eRst[MAXC], eDin[MAXC];
  logic [0:14] eAddr[MAXC];
  logic [0:11] eData[MAXC], eDinVal[MAXC];

  int nChk = 0, nErr = 0;
  int lastGnt = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Compare process: apply scheduled model events, then check every output.
  logic [11:0] mCnt;
  bit          mErr;
  logic [11:0] mDin;
  bit          on = 0;
  int          k;
  always @(negedge clk) begin
    k = cyc;
    if (k < MAXC) begin
      if (eRst[k]) begin on = 1; mCnt = 0; mErr = 0; mDin = 0; end
      if (eCnt[k]) mCnt++;
      if (eErr[k]) mErr = 1;
      if (eDin[k]) mDin = eDinVal[k];
      if (dmaGNT === 1'b1) lastGnt = k;
      if (on) begin
        check("dmaGNT",    dmaGNT,    eGnt[k]);
        check("cpuHOLD",   cpuHOLD,   eHold[k]);
        check("memRD",     memRD,     eRd[k]);
        check("memWR",     memWR,     eWr[k]);
        check("xferCOUNT", xferCOUNT, mCnt);
        check("dmaERR",    dmaERR,    mErr);
        check("dmaDIN",    dmaDIN,    mDin);
        if (eRd[k] || eWr[k]) check("memADDR", memADDR, eAddr[k]);
        if (eWr[k])           check("memDOUT", memDOUT, eData[k]);
        if (eRst[k]) begin
          check("rstADDR", memADDR, 0);
          check("rstDOUT", memDOUT, 0);
        end
      end
    end
  end

  task automatic nextCyc;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit useClear);
    if (useClear) clear = 1'b1; else reset = 1'b1;
    eRst[cyc+1] = 1;
    nextCyc();
    reset = 1'b0;
    clear = 1'b0;
  endtask

  // One sd transfer. d = cycles of cpuACK delay after cpuHOLD rises,
  // stale = extra cycles dmaREQ is held after dmaGNT, abortOff >= 0 asserts
  // clear in cycle e0+abortOff. e0 is the edge dmaREQ is sampled in IDLE.
  task automatic xfer(input bit rd, input bit wr, input logic [0:14] addr,
                      input logic [0:11] data, input logic [0:11] rdExp,
                      input int d, input int stale, input int abortOff,
                      output int e0);
    bit lRd, lWr, lg;
    int strobe, g, cut, dropAt, endAt;
    e0     = cyc + 1;
    lRd    = rd & !wr;
    lWr    = !rd & wr;
    lg     = lRd | lWr;
    strobe = e0 + 1 + d;
    g      = e0 + 2 + d + (lRd ? 1 : 0);
    cut    = (abortOff >= 0) ? e0 + abortOff + 1 : MAXC;
    for (int c = e0; c <= g; c++) if (c < cut) eHold[c] = 1;
    if (strobe < cut) begin
      eRd[strobe] = lRd; eWr[strobe] = lWr;
      eAddr[strobe] = addr; eData[strobe] = data;
    end
    if (g < cut) begin
      eGnt[g] = 1;
      if (lRd) begin eDin[g] = 1; eDinVal[g] = rdExp; end
      if (!lg) eErr[g] = 1;
    end
    if (lg && g + 1 < cut) eCnt[g+1] = 1;
    if (cut < MAXC) eRst[cut] = 1;

    dmaREQ = 1'b1; dmaRD = rd; dmaWR = wr; dmaADDR = addr; dmaDOUT = data;
    if (d > 0) cpuACK = 1'b0;
    dropAt = g + stale;
    endAt  = (abortOff >= 0) ? e0 + abortOff + 2 : dropAt + 2;
    while (cyc < endAt) begin
      nextCyc();
      if (cyc == e0) begin dmaADDR = ~addr; dmaDOUT = ~data; end
      if (d > 0 && cyc == e0 + d) cpuACK = 1'b1;
      if (abortOff >= 0 && cyc == e0 + abortOff) begin clear = 1'b1; dmaREQ = 1'b0; end
      if (abortOff >= 0 && cyc == e0 + abortOff + 1) clear = 1'b0;
      if (abortOff < 0 && cyc == dropAt) dmaREQ = 1'b0;
    end
    cpuACK = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  int e0;
  initial begin
    reset = 1'b1; clear = 1'b0; dmaREQ = 1'b0; dmaRD = 1'b0; dmaWR = 1'b0;
    dmaADDR = '0; dmaDOUT = '0; cpuACK = 1'b1;
    memArr[15'o00200] = 12'o4321;
    memArr[15'o07777] = 12'o1234;
    doReset(0);
    nextCyc();
    check("rst_count", xferCOUNT, 0);
    check("rst_hold",  cpuHOLD,   0);
    check("rst_err",   dmaERR,    0);

    // Write
    xfer(0, 1, 15'o12345, 12'o7070, 12'o0, 0, 0, -1, e0);
    check("wr_latency", lastGnt - e0, 2);
    check("wr_count",   xferCOUNT, 1);
    check("wr_mem",     memArr[15'o12345], 12'o7070);

    // Read
    xfer(1, 0, 15'o00200, 12'o0000, 12'o4321, 0, 0, -1, e0);
    check("rd_latency", lastGnt - e0, 3);
    check("rd_din",     dmaDIN, 12'o4321);
    check("rd_count",   xferCOUNT, 2);

    // CPU stall of 7 cycles
    xfer(0, 1, 15'o00400, 12'o1111, 12'o0, 7, 0, -1, e0);
    check("stall_latency", lastGnt - e0, 9);
    check("stall_count",   xferCOUNT, 3);

    // Stale request held high after grant
    xfer(0, 1, 15'o00401, 12'o2222, 12'o0, 0, 6, -1, e0);
    check("stale_count", xferCOUNT, 4);
    check("stale_hold",  cpuHOLD, 0);

    // Illegal request RD=WR=1
    xfer(1, 1, 15'o00402, 12'o3333, 12'o0, 0, 0, -1, e0);
    check("ill_latency", lastGnt - e0, 2);
    check("ill_err",     dmaERR, 1);
    check("ill_count",   xferCOUNT, 4);
    check("ill_din",     dmaDIN, 12'o4321);

    // Abort during HOLD
    xfer(0, 1, 15'o00403, 12'o4444, 12'o0, 3, 0, 1, e0);
    check("abtH_nognt", lastGnt < e0, 1);
    check("abtH_count", xferCOUNT, 0);
    check("abtH_err",   dmaERR, 0);
    check("abtH_din",   dmaDIN, 0);

    // Abort during RDWAIT
    xfer(0, 1, 15'o00404, 12'o5555, 12'o0, 0, 0, -1, e0);
    xfer(1, 0, 15'o07777, 12'o0000, 12'o0, 0, 0, 2, e0);
    check("abtR_nognt", lastGnt < e0, 1);
    check("abtR_count", xferCOUNT, 0);
    check("abtR_din",   dmaDIN, 0);

    // Count wrap: 4097 writes
    doReset(0);
    nextCyc();
    for (int i = 0; i < 4097; i++)
      xfer(0, 1, 15'(i + 1000), 12'(i), 12'o0, 0, 0, -1, e0);
    check("wrap_count", xferCOUNT, 1);

    nextCyc(); nextCyc();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nErr);
    $finish;
  end

endmodule

// File: doc/rk8e_dma_bridge.md
# rk8e_dma_bridge

Cycle-steal DMA bridge between the RK8E SD disk engine (`sd`) and PDP-8 main memory. It accepts single-word DMA requests from `sd` and holds the CPU off the memory bus at a safe point. It performs one memory read or write and returns `dmaGNT`, plus read data on a read, to `sd`. It sits directly downstream of `sd`'s `dma*` port and upstream of the memory array and CPU bus-hold logic.

## Interface
Parameters:
- none. Widths are fixed: 15-bit extended address, 12-bit word.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous IOCLR; same effect as `reset`.
- `dmaREQ`  in  1  request from `sd`; held high until `dmaGNT` is seen.
- `dmaRD`  in  1  request is a memory read (data into disk).
- `dmaWR`  in  1  request is a memory write (data out of disk).
- `dmaADDR`  in  [0:14]  memory address.
- `dmaDOUT`  in  [0:11]  write data from `sd`.
- `dmaGNT`  out  1  one-cycle completion strobe to `sd`.
- `dmaDIN`  out  [0:11]  read data to `sd`; valid from the `dmaGNT` cycle until the next read completes.
- `cpuHOLD`  out  1  stall request to the CPU.
- `cpuACK`  in  1  CPU is parked at a bus-safe point while `cpuHOLD` is high.
- `memADDR`  out  [0:14]  memory address.
- `memDOUT`  out  [0:11]  memory write data.
- `memRD`  out  1  one-cycle read strobe.
- `memWR`  out  1  one-cycle write strobe.
- `memDIN`  in  [0:11]  memory read data; valid exactly one cycle after `memRD`.
- `xferCOUNT`  out  [0:11]  count of successful transfers; wraps from 4095 to 0.
- `dmaERR`  out  1  sticky flag for an illegal request.

## Operation
- State machine states: IDLE, HOLD, MEM, RDWAIT, DONE, RELEASE.
- **IDLE**
  - On `dmaREQ`=1, latch `dmaADDR`, `dmaDOUT`, `dmaRD` and `dmaWR`, then go to HOLD.
  - `sd` keeps these inputs stable while `dmaREQ` is high, but the bridge uses only the latched copies.
- **HOLD**
  - `cpuHOLD`=1.
  - Wait for `cpuACK`=1, then go to MEM.
  - There is no timeout.
- **MEM**
  - `memADDR` = latched address.
  - If the latched request is a legal write (RD=0, WR=1): `memWR`=1 and `memDOUT` = latched data, then go to DONE.
  - If it is a legal read (RD=1, WR=0): `memRD`=1, then go to RDWAIT.
  - If it is illegal (RD=WR): issue no strobe, set `dmaERR`, then go to DONE.
- **RDWAIT**: capture `memDIN` into `dmaDIN`, then go to DONE.
- **DONE**
  - `dmaGNT`=1 for exactly this cycle.
  - `cpuHOLD` remains 1.
  - `xferCOUNT` increments only for legal transfers.
  - Then go to RELEASE.
- **RELEASE**
  - `cpuHOLD`=0.
  - Stay here until `dmaREQ`=0, then go to IDLE.
  - A new request therefore needs at least one low cycle of `dmaREQ`. This guards against double-counting a stale request.
- All outputs are registered or decoded from state.
  - `cpuHOLD` is 1 only in HOLD, MEM, RDWAIT and DONE.
  - `memRD` and `memWR` are never both high.
- **Reset/clear**, at any state:
  - Next state is IDLE.
  - `cpuHOLD`, `memRD`, `memWR` and `dmaGNT` = 0.
  - `dmaDIN`, `memADDR`, `memDOUT` and `xferCOUNT` = 0.
  - `dmaERR` = 0.
  - A transfer in flight is abandoned. Memory strobes last one cycle, so no partial write is possible.
  - `reset` and `clear` take priority over every other event in the same cycle.

## Timing
- Edge E0 is the edge at which `dmaREQ`=1 is sampled in IDLE. Assume `cpuACK` is already high.
- Write:
  - `memWR` is high during cycle E1–E2.
  - `dmaGNT` is high during cycle E2–E3.
- Read:
  - `memRD` is high during cycle E1–E2.
  - `memDIN` is sampled at E3.
  - `dmaGNT` and valid `dmaDIN` appear during cycle E3–E4.
- Each cycle of `cpuACK` delay adds one cycle to both paths.
- `cpuACK` is ignored outside HOLD.
- `dmaREQ` dropping before DONE has no effect; the transfer completes.
- Minimum back-to-back spacing: 5 cycles per write and 6 per read, from one `dmaGNT` to the next. This is with `sd` dropping `dmaREQ` the cycle after `dmaGNT` and re-raising it one cycle later.

## Test plan
- **Write.** Reset, `cpuACK`=1, `dmaREQ`/`dmaWR` with addr 15'o12345 and data 12'o7070.
  - `memWR` for one cycle with `memADDR`=15'o12345 and `memDOUT`=12'o7070.
  - `dmaGNT` for one cycle, 2 edges after request.
  - `xferCOUNT`=1.
- **Read.** Memory model returns 12'o4321 for addr 15'o00200.
  - `dmaGNT` 3 edges after request.
  - `dmaDIN`=12'o4321.
  - `memWR` never asserted.
- **CPU stall.** Hold `cpuACK`=0 for 7 cycles after `cpuHOLD` rises.
  - No memory strobe until `cpuACK`=1.
  - `dmaGNT` is delayed by exactly 7 cycles.
- **Stale request and illegal request.**
  - Keep `dmaREQ` high after `dmaGNT`: no second transfer, the bridge stays in RELEASE, and `cpuHOLD`=0.
  - Request with RD=WR=1: no `memRD`/`memWR`, `dmaGNT` still pulses, `dmaERR`=1, and `xferCOUNT` is unchanged.
- **Abort.** Assert `clear` during HOLD, and separately during RDWAIT.
  - All outputs return to reset values the next cycle.
  - No `dmaGNT` is produced.
  - `dmaERR` and `xferCOUNT` are 0.
- **Count wrap.** Perform 4097 writes: `xferCOUNT` reads 1.
